uart_rx: RTL
============

# uart_rx

Asynchronous serial receiver: 8N1 frames, LSB first, idle-high line. It is the receive-side counterpart of the transmitter stage on the same board, and uses the same baud-length convention: an integer number of sysclk cycles per bit. It synchronizes the pin and validates the start bit at mid-bit. It assembles the byte, checks the stop bit, and presents the byte through a one-entry valid/ready holding register to downstream logic.

## Interface
- `CLKS_PER_BIT`, default 1085 (125 MHz / 115200): sysclk cycles per bit. Must be ≥ 4.
- `MID`, default `CLKS_PER_BIT/2` (integer division): in-bit sample offset. Derived localparam; not overridable.

- `sysclk` in 1: system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `UART_RX` in 1: serial line, asynchronous to `sysclk`.
- `data` out 8: received byte. Valid while `data_valid` is 1.
- `data_valid` out 1: holding register full.
- `data_ready` in 1: consumer accepts `data` on a cycle where `data_valid && data_ready`.
- `frame_error` out 1: one-cycle pulse when the stop bit is sampled as 0.
- `overrun` out 1: one-cycle pulse when a good byte is dropped because the holding register is full.

## Operation
- **Synchronizer:** 2-flop synchronizer on `UART_RX`, both flops reset to 1. Output `rx_s`. All logic below uses only `rx_s`.
- **Bit timer:** `cnt` runs 0..CLKS_PER_BIT-1, wraps to 0, and is held at 0 in IDLE and RECOVER. Its width is `$clog2(CLKS_PER_BIT)`.
- **Bit decision:** `bit_val` is decided when `cnt == MID+1`.
  - Default: `bit_val` is `rx_s` captured at `cnt == MID`.
  - See Configuration for the alternative.
- **States:**
  - **IDLE:** when `rx_s == 0`, go to START; `cnt` is 0 on the next cycle.
  - **START:** at the decision point:
    - `bit_val == 1` means a false start; go to IDLE with no output.
    - Otherwise, at `cnt == CLKS_PER_BIT-1`, go to DATA with `idx = 0`.
  - **DATA:** at the decision point, shift `bit_val` into the shift register MSB-first-in (so the LSB arrives first). At `cnt == CLKS_PER_BIT-1`:
    - If `idx == 7`, go to STOP.
    - Otherwise, increment `idx`.
  - **STOP:** at the decision point:
    - `bit_val == 1`: deliver the byte (see below), then go to IDLE immediately; the remainder of the stop bit is not waited for.
    - `bit_val == 0`: pulse `frame_error`, discard the byte, go to RECOVER.
  - **RECOVER:** stay until `rx_s == 1`, then go to IDLE. A held-low line (break) produces exactly one `frame_error` and no further frames.
- **Delivery:**
  - If the holding register is empty, or being accepted this cycle (`data_valid && data_ready`), load `data` and keep/set `data_valid` = 1. No overrun.
  - Otherwise, pulse `overrun`. The old `data` is retained and the new byte is dropped.
- **Accept without delivery:** `data_valid && data_ready` with no delivery in the same cycle clears `data_valid` next cycle.
- **Stability:** `data` must not change while `data_valid == 1` except on a same-cycle accept+deliver.

## Timing
- **Reset values:** state IDLE, `cnt` 0, `idx` 0, shift register 0, `data` 0x00, `data_valid` 0, `frame_error` 0, `overrun` 0, synchronizer flops 1.
- **Reset mid-frame:** aborts the frame; nothing is delivered.
- **Latency:** let t be the first cycle with `rx_s == 0` in IDLE.
  - Frame outputs (`data_valid` rising, `frame_error`, `overrun`) appear registered at cycle t + 9·CLKS_PER_BIT + MID + 3.
  - Pin-to-`rx_s` delay is 2 cycles.
- **Back-to-back frames:** a start bit following the stop bit with no idle gap is received correctly, because IDLE is re-entered mid-stop.
- **Pulse outputs:** `frame_error` and `overrun` are exactly 1 cycle wide and never asserted together.
- **Holding register:** `data_valid` drops only on an accept. It is independent of line activity.

## Configuration
- `UART_RX_MAJORITY_EN` defined: `bit_val` is the 2-of-3 majority of `rx_s` captured at `cnt == MID-1`, `MID`, and `MID+1`.
  - The decision is still at `cnt == MID+1`; the MID+1 sample is used combinationally.
  - Applies to the START, DATA and STOP decisions.
  - Latency is unchanged.
- Not defined: single sample at `cnt == MID` and no extra sample registers.

## Test plan
All tests use CLKS_PER_BIT=16, MID=8.
- **Basic receive:** drive 0x41 (bits 0,1,0,0,0,0,0,1,0 then stop 1) at 16 cycles/bit with `data_ready` = 1 → single `data_valid` cycle with `data` = 0x41 at t+155. No `frame_error`/`overrun`.
- **False start:** 4-cycle low glitch on an idle line → no `data_valid` and no `frame_error`; FSM back in IDLE; a following 0xA5 frame is received as 0xA5.
- **Frame error and break:** frame 0x3C with stop = 0, then line held low for 40 bit-times, then released → exactly one `frame_error` pulse, `data_valid` stays 0; a subsequent 0x81 frame is received correctly.
- **Overrun and same-cycle accept:**
  - `data_ready` = 0, send 0x11 then 0x22 back-to-back → `data` = 0x11 held, `overrun` pulses once at the second frame's delivery cycle; raising `data_ready` then clears `data_valid`.
  - Repeat with `data_ready` pulsed exactly on the second delivery cycle → `data` = 0x22, `data_valid` stays 1, no `overrun`.
- **Reset mid-frame:** assert `rst` for 2 cycles during bit 4 of 0xFF → all outputs at reset values; the next full 0x5A frame yields 0x5A.
- **Majority vote:** 1-cycle inverted pulse at `cnt == MID` on bit 0 of 0x00 → 0x00 with `UART_RX_MAJORITY_EN`, 0x01 without.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 2-flop sync, mid-bit sampling and a one-entry valid/ready holding register.
// Define UART_RX_MAJORITY_EN to decide each bit by 2-of-3 vote around mid-bit.
module uart_rx #(
  parameter int CLKS_PER_BIT = 1085
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       UART_RX,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_error,
  output logic       overrun
);
  localparam int MID = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_MID = CW'(MID);
  localparam logic [CW-1:0] C_DEC = CW'(MID + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, RECOVER} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sh_q, sh_d, data_q, data_d;
  logic valid_q, valid_d, fe_q, fe_d, ov_q, ov_d;
  logic s1_q, s2_q, rx_s, bit_val, dec;
  assign rx_s = s2_q;
  assign dec = cnt_q == C_DEC;
  assign data = data_q;
  assign data_valid = valid_q;
  assign frame_error = fe_q;
  assign overrun = ov_q;
`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] C_PRE = CW'(MID - 1);
  logic smp0_q, smp1_q;
  always_ff @(posedge sysclk or posedge rst)
    if (rst) begin
      smp0_q <= 1'b1;
      smp1_q <= 1'b1;
    end else begin
      if (cnt_q == C_PRE) smp0_q <= rx_s;
      if (cnt_q == C_MID) smp1_q <= rx_s;
    end
  // third vote is the live MID+1 sample, so the decision cycle stays the same
  assign bit_val = (smp0_q & smp1_q) | (smp0_q & rx_s) | (smp1_q & rx_s);
`else
  logic smp_q;
  always_ff @(posedge sysclk or posedge rst)
    if (rst) smp_q <= 1'b1;
    else if (cnt_q == C_MID) smp_q <= rx_s;
  assign bit_val = smp_q;
`endif
  always_ff @(posedge sysclk or posedge rst)
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      sh_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      fe_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      s1_q <= UART_RX;
      s2_q <= s1_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
      data_q <= data_d;
      valid_q <= valid_d;
      fe_q <= fe_d;
      ov_q <= ov_d;
    end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    sh_d = sh_q;
    data_d = data_q;
    valid_d = valid_q & ~data_ready;
    fe_d = 1'b0;
    ov_d = 1'b0;
    case (state_q)
      IDLE: if (!rx_s) state_d = START;
      START:
        if (dec && bit_val) state_d = IDLE;
        else if (cnt_q == C_LAST) begin
          state_d = DATA;
          idx_d = '0;
        end
      DATA: begin
        if (dec) sh_d = {bit_val, sh_q[7:1]};
        if (cnt_q == C_LAST) begin
          if (idx_q == 3'd7) state_d = STOP;
          else idx_d = idx_q + 3'd1;
        end
      end
      STOP:
        if (dec) begin
          // leave mid-stop so a back-to-back start bit is not missed
          state_d = bit_val ? IDLE : RECOVER;
          fe_d = ~bit_val;
          if (bit_val) begin
            if (!valid_q || data_ready) begin
              data_d = sh_q;
              valid_d = 1'b1;
            end else ov_d = 1'b1;
          end
        end
      RECOVER: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cnt_d = (state_q inside {START, DATA, STOP} && state_d inside {START, DATA, STOP})
          ? ((cnt_q == C_LAST) ? '0 : cnt_q + 1'b1) : '0;
  end
endmodule
